// File: rtl/window_scheduler.sv
// window_scheduler: sequences the sliding-window pixel engine over one frame.
// Restarts the engine at the origin, paces per-window triggers against
// downstream readiness, tracks window coordinates and frames each burst.
module window_scheduler #(
  parameter int COLS = 86,
  parameter int ROWS = 107,
  parameter int TMO  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        out_ready,
  input  logic        win_write,
  output logic        eng_rst,
  output logic        req_out,
  output logic        pix_valid,
  output logic        pix_last,
  output logic [6:0]  win_x,
  output logic [6:0]  win_y,
  output logic [13:0] win_idx,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE, RESTART, WAIT_RDY, TRIG, GAP, ARMED, STREAM, ADV
  } state_t;

  localparam int          TW     = $clog2(TMO + 1);
  localparam logic [6:0]  X_LAST = 7'(COLS - 1);
  localparam logic [6:0]  Y_LAST = 7'(ROWS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;

  // Busy is a pure decode of the state register.
  assign busy = (state != IDLE);

  // The first pixel arrives while still ARMED, so ARMED passes it through too.
  assign pix_valid = win_write && ((state == ARMED) || (state == STREAM));

  // Frame sequencer: state, coordinates, timeout counter and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      eng_rst    <= 1'b0;
      req_out    <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      win_idx    <= '0;
    end else begin
      eng_rst    <= 1'b0;
      req_out    <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RESTART;
              eng_rst <= 1'b1;
              win_x   <= '0;
              win_y   <= '0;
              win_idx <= '0;
              timeout <= 1'b0;
            end
          end
          RESTART: begin
            state   <= ARMED;
            tmo_cnt <= '0;
          end
          WAIT_RDY: begin
            if (out_ready) begin
              state   <= TRIG;
              req_out <= 1'b1;
            end
          end
          TRIG: state <= GAP;
          GAP: begin
            state   <= ARMED;
            tmo_cnt <= '0;
          end
          ARMED: begin
            if (win_write) begin
              state <= STREAM;
            end else if (tmo_cnt == T_LAST) begin
              state   <= IDLE;
              timeout <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          STREAM: begin
            if (!win_write) begin
              state    <= ADV;
              pix_last <= 1'b1;
            end
          end
          ADV: begin
            if ((win_x == X_LAST) && (win_y == Y_LAST)) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              state   <= WAIT_RDY;
              win_idx <= win_idx + 14'd1;
              if (win_x == X_LAST) begin
                win_x <= '0;
                win_y <= win_y + 7'd1;
              end else begin
                win_x <= win_x + 7'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_scheduler.sv
// tb_window_scheduler: directed bench for window_scheduler with an engine model
// and a window scoreboard checked on every pix_last.
module tb_window_scheduler;

  localparam int COLS = 6;
  localparam int ROWS = 4;
  localparam int TMO  = 16;
  localparam int NPIX = 225;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready, win_write;
  logic        eng_rst, req_out, pix_valid, pix_last, busy, frame_done, timeout;
  logic [6:0]  win_x, win_y;
  logic [13:0] win_idx;

  typedef struct { int x; int y; } win_t;
  win_t sb[$];

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int windows = 0;
  bit mute = 1'b0;

  window_scheduler #(.COLS(COLS), .ROWS(ROWS), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .out_ready(out_ready), .win_write(win_write), .eng_rst(eng_rst),
    .req_out(req_out), .pix_valid(pix_valid), .pix_last(pix_last),
    .win_x(win_x), .win_y(win_y), .win_idx(win_idx), .busy(busy),
    .frame_done(frame_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Engine model: window 0 on eng_rst, next window on each req_out rising edge.
  initial begin : engine
    int ex, ey;
    bit go, prev_req;
    ex = 0; ey = 0; prev_req = 1'b0;
    win_write = 1'b0;
    forever begin
      @(posedge clk); #1;
      go = 1'b0;
      if (rst_n && eng_rst) begin
        ex = 0; ey = 0; go = 1'b1;
      end else if (rst_n && req_out && !prev_req) begin
        if (ex == COLS - 1) begin ex = 0; ey++; end else ex++;
        go = 1'b1;
      end
      prev_req = req_out;
      if (go) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (!mute && rst_n) begin
          sb.push_back('{x: ex, y: ey});
          win_write = 1'b1;
          for (int i = 0; i < NPIX; i++) begin
            @(posedge clk); #1;
            if (!rst_n) break;
          end
          win_write = 1'b0;
        end
        prev_req = req_out;
      end
    end
  end

  // Output monitor: pixel counting, scoreboard pops and coordinate advance.
  initial begin : monitor
    int pixcnt, lx, ly, nx, ny;
    bit prev_last;
    win_t e;
    pixcnt = 0; lx = 0; ly = 0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pixcnt = 0;
        prev_last = 1'b0;
      end else begin
        if (prev_last && !(lx == COLS - 1 && ly == ROWS - 1)) begin
          nx = (lx == COLS - 1) ? 0 : lx + 1;
          ny = (lx == COLS - 1) ? ly + 1 : ly;
          check("adv_x", 32'(win_x), 32'(nx));
          check("adv_y", 32'(win_y), 32'(ny));
          check("adv_idx", 32'(win_idx), 32'(ny * COLS + nx));
        end
        prev_last = 1'b0;
        if (frame_done) fd_count++;
        if (pix_valid) pixcnt++;
        if (pix_last) begin
          check("sb_pending", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("win_x", 32'(win_x), 32'(e.x));
            check("win_y", 32'(win_y), 32'(e.y));
            check("win_idx", 32'(win_idx), 32'(e.y * COLS + e.x));
            check("pix_count", 32'(pixcnt), 32'(NPIX));
            lx = e.x; ly = e.y;
            prev_last = 1'b1;
            windows++;
          end
          pixcnt = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Directed sequence.
  initial begin : stim
    bit seen, ok;
    int fd_snap;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(req_out), 32'd0);
    check("rst_eng_rst", 32'(eng_rst), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_idx", 32'(win_idx), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame, with out_ready withheld after window 0.
    pulse_start();
    check("start_eng_rst", 32'(eng_rst), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("eng_rst_one_cycle", 32'(eng_rst), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (pix_last) ok = 1'b1; else @(negedge clk);
    end
    check("first_window_done", 32'(ok), 32'd1);
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_out) seen = 1'b1;
    end
    check("req_held_while_not_ready", 32'(seen), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("req_after_ready", 32'(req_out), 32'd1);
    @(negedge clk);
    check("req_one_cycle", 32'(req_out), 32'd0);
    for (int i = 0; i < 20000 && fd_count == 0; i++) @(negedge clk);
    check("frame_done_seen", 32'(fd_count), 32'd1);
    check("final_idx", 32'(win_idx), 32'(COLS * ROWS - 1));
    check("frame_windows", 32'(windows), 32'(COLS * ROWS));
    repeat (5) @(negedge clk);
    check("frame_done_once", 32'(fd_count), 32'd1);
    check("idle_after_frame", 32'(busy), 32'd0);

    // Reset in the middle of a stream.
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (pix_valid) ok = 1'b1;
    end
    check("stream_reached", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_req", 32'(req_out), 32'd0);
    check("mrst_idx", 32'(win_idx), 32'd0);
    check("mrst_pix_valid", 32'(pix_valid), 32'd0);
    check("mrst_pix_last", 32'(pix_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);

    // Engine never responds.
    mute = 1'b1;
    pulse_start();
    repeat (16) @(negedge clk);
    check("tmo_armed_busy", 32'(busy), 32'd1);
    check("tmo_not_yet", 32'(timeout), 32'd0);
    @(negedge clk);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_set", 32'(timeout), 32'd1);
    repeat (3) @(negedge clk);
    check("tmo_sticky", 32'(timeout), 32'd1);
    mute = 1'b0;
    pulse_start();
    check("tmo_cleared", 32'(timeout), 32'd0);

    // Abort while ARMED for window 10.
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (req_out && win_idx == 14'd10) ok = 1'b1;
    end
    check("win10_trigger", 32'(ok), 32'd1);
    mute = 1'b1;
    fd_snap = fd_count;
    @(posedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done_later", 32'(fd_count), 32'(fd_snap));
    mute = 1'b0;
    pulse_start();
    check("restart_eng_rst", 32'(eng_rst), 32'd1);
    check("restart_x", 32'(win_x), 32'd0);
    check("restart_y", 32'(win_y), 32'd0);
    check("restart_idx", 32'(win_idx), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (pix_last) ok = 1'b1;
    end
    check("restart_window_done", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_scheduler.md
# window_scheduler

Sequencing controller for the sliding-window pixel engine. It restarts the engine at the origin on a frame start and issues one trigger per window. Triggers are paced against a downstream ready signal so that no window is started while the DNN input stage cannot absorb it. It tracks window coordinates and index, frames each window's pixel burst with valid/last strobes, and flags engines that never respond.

## Interface

Parameters:
- COLS, 86: window positions per row (x range 0..COLS-1).
- ROWS, 107: window rows (y range 0..ROWS-1).
- TMO, 16: max cycles from trigger to first pixel before timeout.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a frame when idle, ignored otherwise.
- abort  input  1  synchronous; returns to IDLE next edge, no frame_done.
- out_ready  input  1  downstream can accept one full window.
- win_write  input  1  engine pixel-write strobe (high while window count < 225).
- eng_rst  output  1  synchronous active-high restart to engine.
- req_out  output  1  engine trigger level; engine acts on its rising edge.
- pix_valid  output  1  current engine pixel belongs to the active window.
- pix_last  output  1  first cycle after final pixel of a window (win_write fell).
- win_x  output  7  current window column.
- win_y  output  7  current window row.
- win_idx  output  14  linear window index, win_y*COLS+win_x.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse after the last window completes.
- timeout  output  1  sticky error; cleared by start or reset.

## Operation

- States: IDLE, RESTART, WAIT_RDY, TRIG, GAP, ARMED, STREAM, ADV.
- IDLE: all strobes low. start -> RESTART, clears win_x/win_y/win_idx and timeout.
- RESTART: eng_rst=1 for exactly one cycle. The engine begins window (0,0) without a trigger -> ARMED.
- WAIT_RDY: hold until out_ready=1 -> TRIG.
- TRIG: req_out=1 for exactly one cycle -> GAP.
- GAP: req_out=0 for one cycle, guaranteeing a low phase before the next trigger -> ARMED.
- ARMED: wait for win_write=1 -> STREAM. A cycle counter starts on ARMED entry; if it reaches TMO -> timeout=1, IDLE.
- STREAM: pix_valid=win_write. On win_write 1->0 -> ADV, with pix_last=1 during the ADV cycle.
- ADV: if (win_x,win_y)=(COLS-1,ROWS-1) -> frame_done=1, IDLE. Otherwise advance win_x, or wrap win_x to 0 and increment win_y. win_idx +1. -> WAIT_RDY.
- Coordinates follow the engine's scan order, x fastest. win_idx maximum is 9201; it never wraps within a frame.
- The first window is gated by ARMED only. The ready check applies from the second window on. The frame issuer must hold out_ready before start.
- abort has priority over all transitions. start is ignored while busy.
- Asynchronous reset: state IDLE. All outputs 0, coordinates 0, timeout 0.
- win_write is sampled only in ARMED and STREAM. Glitches in other states are ignored.

## Timing

- start at edge N: RESTART in cycle N+1 (eng_rst=1, busy=1), ARMED from N+2.
- Trigger spacing: ADV -> WAIT_RDY -> TRIG. With out_ready=1, req_out rises 2 cycles after the window's last pixel.
- req_out is high exactly 1 cycle and low at least 1 cycle between pulses.
- pix_valid is combinational from win_write gated by state; zero added latency.
- pix_last, frame_done and timeout are registered outputs.
- Per-window overhead with out_ready=1: ADV, WAIT_RDY, TRIG, GAP (4 cycles) plus engine response.

## Test plan

- Reset mid-STREAM (rst_n low 1 cycle) -> next cycle busy=0, req_out=0, win_idx=0, all strobes 0.
- start, engine model streams 225 pixels per window, out_ready=1 -> exactly 225 pix_valid per window and one pix_last per window. After window (85,106), win_idx=9201 and frame_done pulses once.
- out_ready held low 50 cycles after window 0 -> req_out stays 0; it rises 1 cycle after out_ready returns high.
- After window (85,0) completes -> win_x=0, win_y=1, win_idx=86.
- Engine model never raises win_write after a trigger -> timeout=1 after 16 ARMED cycles, state IDLE. A later start clears timeout.
- abort asserted during ARMED of window 10 -> IDLE next cycle, no frame_done. start again -> eng_rst pulse and coordinates at (0,0).
